// File: rtl/axi_xbar_pkg.sv
// Shared AXI crossbar definitions: default widths, RRESP codes,
// read-response arbiter FSM states and a mod-3 slot increment helper.
package axi_xbar_pkg;

    localparam int ID_W_DEF   = 4;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_EXOKAY = 2'b01;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] RRESP_DECERR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } rd_arb_state_e;

    function automatic logic [1:0] inc3(input logic [1:0] i);
        return (i >= 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// 3-way round-robin pick starting at slot ptr, wrapping 2->0.
// Ports: req[2:0], ptr[1:0] in; one-hot grant[2:0], idx[1:0] out.
module rr_arb3
    import axi_xbar_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] grant,
    output logic [1:0] idx
);

    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;

    // ptr never holds 3; folding it to 0 keeps the pick well defined
    assign c0 = (ptr == 2'd3) ? 2'd0 : ptr;
    assign c1 = inc3(c0);
    assign c2 = inc3(c1);

    always_comb begin
        idx   = 2'd0;
        grant = 3'b000;
        if (req[c0]) begin
            idx = c0;
        end else if (req[c1]) begin
            idx = c1;
        end else if (req[c2]) begin
            idx = c2;
        end
        if (|req) begin
            grant = 3'b001 << idx;
        end
    end

endmodule

// File: rtl/read_resp_arbiter.sv
// Merges three slave R streams into one master R stream, burst-locked.
// Ports: clk, rst_n; sN_axi_r_{rid,rdata,rresp,rlast,valid} in and
// sN_axi_r_ready out (N=0..2); m_axi_r_{rid,rdata,rresp,rlast,valid}
// out and m_axi_r_ready in. Define RD_RESP_ARB_OUT_REG_EN for a
// registered master side (latency 1, full throughput).
module read_resp_arbiter
    import axi_xbar_pkg::*;
#(
    parameter int ID_W   = ID_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   s0_axi_r_rid,
    input  logic [DATA_W-1:0] s0_axi_r_rdata,
    input  logic [1:0]        s0_axi_r_rresp,
    input  logic              s0_axi_r_rlast,
    input  logic              s0_axi_r_valid,
    output logic              s0_axi_r_ready,
    input  logic [ID_W-1:0]   s1_axi_r_rid,
    input  logic [DATA_W-1:0] s1_axi_r_rdata,
    input  logic [1:0]        s1_axi_r_rresp,
    input  logic              s1_axi_r_rlast,
    input  logic              s1_axi_r_valid,
    output logic              s1_axi_r_ready,
    input  logic [ID_W-1:0]   s2_axi_r_rid,
    input  logic [DATA_W-1:0] s2_axi_r_rdata,
    input  logic [1:0]        s2_axi_r_rresp,
    input  logic              s2_axi_r_rlast,
    input  logic              s2_axi_r_valid,
    output logic              s2_axi_r_ready,
    output logic [ID_W-1:0]   m_axi_r_rid,
    output logic [DATA_W-1:0] m_axi_r_rdata,
    output logic [1:0]        m_axi_r_rresp,
    output logic              m_axi_r_rlast,
    output logic              m_axi_r_valid,
    input  logic              m_axi_r_ready
);

    rd_arb_state_e state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    own_q, own_d;

    logic [2:0]        vld;
    logic [2:0]        arb_grant;
    logic [1:0]        arb_idx;
    logic [1:0]        sel;
    logic              sel_valid;
    logic [ID_W-1:0]   sel_rid;
    logic [DATA_W-1:0] sel_rdata;
    logic [1:0]        sel_rresp;
    logic              sel_rlast;
    logic              down_ready;
    logic              xfer;
    logic [2:0]        rdy;

    assign vld = {s2_axi_r_valid, s1_axi_r_valid, s0_axi_r_valid};

    rr_arb3 u_arb (
        .req   (vld),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign sel = (state_q == ST_LOCK) ? own_q : arb_idx;

    // Idle with no request leaves sel at 0, so the mux shows slave 0
    always_comb begin
        sel_valid = s0_axi_r_valid;
        sel_rid   = s0_axi_r_rid;
        sel_rdata = s0_axi_r_rdata;
        sel_rresp = s0_axi_r_rresp;
        sel_rlast = s0_axi_r_rlast;
        case (sel)
            2'd1: begin
                sel_valid = s1_axi_r_valid;
                sel_rid   = s1_axi_r_rid;
                sel_rdata = s1_axi_r_rdata;
                sel_rresp = s1_axi_r_rresp;
                sel_rlast = s1_axi_r_rlast;
            end
            2'd2: begin
                sel_valid = s2_axi_r_valid;
                sel_rid   = s2_axi_r_rid;
                sel_rdata = s2_axi_r_rdata;
                sel_rresp = s2_axi_r_rresp;
                sel_rlast = s2_axi_r_rlast;
            end
            default: ;
        endcase
    end

`ifdef RD_RESP_ARB_OUT_REG_EN
    logic              m_valid_q;
    logic [ID_W-1:0]   m_rid_q;
    logic [DATA_W-1:0] m_rdata_q;
    logic [1:0]        m_rresp_q;
    logic              m_rlast_q;

    // Slice can take a beat when empty or draining this cycle
    assign down_ready = !m_valid_q || m_axi_r_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_rid_q   <= '0;
            m_rdata_q <= '0;
            m_rresp_q <= '0;
            m_rlast_q <= 1'b0;
        end else if (down_ready) begin
            m_valid_q <= sel_valid;
            if (sel_valid) begin
                m_rid_q   <= sel_rid;
                m_rdata_q <= sel_rdata;
                m_rresp_q <= sel_rresp;
                m_rlast_q <= sel_rlast;
            end
        end
    end

    assign m_axi_r_valid = m_valid_q;
    assign m_axi_r_rid   = m_rid_q;
    assign m_axi_r_rdata = m_rdata_q;
    assign m_axi_r_rresp = m_rresp_q;
    assign m_axi_r_rlast = m_rlast_q;
`else
    assign down_ready = m_axi_r_ready;

    // rst_n gating makes the pass-through quiet while reset is held
    assign m_axi_r_valid = rst_n && sel_valid;
    assign m_axi_r_rid   = rst_n ? sel_rid   : '0;
    assign m_axi_r_rdata = rst_n ? sel_rdata : '0;
    assign m_axi_r_rresp = rst_n ? sel_rresp : '0;
    assign m_axi_r_rlast = rst_n && sel_rlast;
`endif

    assign xfer = rst_n && sel_valid && down_ready;

    // The owner keeps ready through valid gaps so the burst stays locked
    always_comb begin
        rdy = 3'b000;
        if (rst_n && down_ready) begin
            if (state_q == ST_LOCK) begin
                rdy = 3'b001 << own_q;
            end else begin
                rdy = arb_grant;
            end
        end
    end

    assign s0_axi_r_ready = rdy[0];
    assign s1_axi_r_ready = rdy[1];
    assign s2_axi_r_ready = rdy[2];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        if (xfer) begin
            if (sel_rlast) begin
                state_d = ST_IDLE;
                ptr_d   = inc3(sel);
            end else if (state_q == ST_IDLE) begin
                state_d = ST_LOCK;
                own_d   = sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            own_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
        end
    end

endmodule

// File: tb/tb_read_resp_arbiter.sv
// Directed bench for read_resp_arbiter: burst order, lock, stalls,
// single beats, async reset and output latency.
module tb_read_resp_arbiter;
    import axi_xbar_pkg::*;

`ifdef RD_RESP_ARB_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        logic [31:0] d;
        logic [3:0]  id;
        logic [1:0]  r;
        logic        l;
        int          c;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  s_rid  [3];
    logic [31:0] s_data [3];
    logic [1:0]  s_resp [3];
    logic [2:0]  s_last;
    logic [2:0]  s_valid;
    logic        r0, r1, r2;
    logic [2:0]  s_ready;
    logic [3:0]  m_rid;
    logic [31:0] m_data;
    logic [1:0]  m_resp;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;

    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    beat_t q[$];
    int    stall_n = 0;
    int    stall_err = 0;
    int    lock_n = 0;
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [31:0] pd = '0;

    assign s_ready = {r2, r1, r0};

    always #5 clk = ~clk;

    read_resp_arbiter #(.ID_W(4), .DATA_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s0_axi_r_rid   (s_rid[0]),
        .s0_axi_r_rdata (s_data[0]),
        .s0_axi_r_rresp (s_resp[0]),
        .s0_axi_r_rlast (s_last[0]),
        .s0_axi_r_valid (s_valid[0]),
        .s0_axi_r_ready (r0),
        .s1_axi_r_rid   (s_rid[1]),
        .s1_axi_r_rdata (s_data[1]),
        .s1_axi_r_rresp (s_resp[1]),
        .s1_axi_r_rlast (s_last[1]),
        .s1_axi_r_valid (s_valid[1]),
        .s1_axi_r_ready (r1),
        .s2_axi_r_rid   (s_rid[2]),
        .s2_axi_r_rdata (s_data[2]),
        .s2_axi_r_rresp (s_resp[2]),
        .s2_axi_r_rlast (s_last[2]),
        .s2_axi_r_valid (s_valid[2]),
        .s2_axi_r_ready (r2),
        .m_axi_r_rid    (m_rid),
        .m_axi_r_rdata  (m_data),
        .m_axi_r_rresp  (m_resp),
        .m_axi_r_rlast  (m_last),
        .m_axi_r_valid  (m_valid),
        .m_axi_r_ready  (m_ready)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Master-side monitor: beats, stall stability, LOCK occupancy
    always @(negedge clk) begin
        if (!rst_n) begin
            pv <= 1'b0;
            pr <= 1'b0;
        end else begin
            if (m_valid && m_ready)
                q.push_back('{m_data, m_rid, m_resp, m_last, cyc});
            if (pv && !pr) begin
                stall_n <= stall_n + 1;
                if (!(m_valid && m_data == pd))
                    stall_err <= stall_err + 1;
            end
            if (dut.state_q == ST_LOCK)
                lock_n <= lock_n + 1;
            pv <= m_valid;
            pr <= m_ready;
            pd <= m_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int s, input int n, input logic [31:0] base,
                         input logic [1:0] resp, input int dly);
        int   b;
        int   guard;
        logic fire;
        if (dly > 0) begin
            repeat (dly) @(posedge clk);
            #1;
        end
        b = 0;
        guard = 0;
        while (b < n && guard < 200) begin
            s_valid[s] = 1'b1;
            s_data[s]  = base + 32'(b);
            s_last[s]  = (b == n - 1);
            s_resp[s]  = resp;
            s_rid[s]   = 4'(s + 1);
            @(negedge clk);
            fire = s_ready[s];
            @(posedge clk);
            #1;
            if (fire) b++;
            guard++;
        end
        s_valid[s] = 1'b0;
        s_last[s]  = 1'b0;
        chk($sformatf("drv%0d_done", s), 32'(b), 32'(n));
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int ln;
        int sn;
        int se;
        rst_n   = 1'b0;
        m_ready = 1'b0;
        s_last  = '0;
        for (int i = 0; i < 3; i++) begin
            s_rid[i]  = 4'(i + 1);
            s_data[i] = 32'hDEAD_0000 + 32'(i);
            s_resp[i] = 2'b00;
        end
        s_valid = 3'b111;
        #1;
        chk("rst_ready", 32'(s_ready), 32'h0);
        chk("rst_mvalid", 32'(m_valid), 32'h0);
        chk("rst_mdata", m_data, 32'h0);
        chk("rst_mrid", 32'(m_rid), 32'h0);
        repeat (2) @(posedge clk);
        chk("rst_ptr", 32'(dut.ptr_q), 32'h0);
        chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        s_valid = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three simultaneous 4-beat bursts
        m_ready = 1'b1;
        q.delete();
        fork
            drive(0, 4, 32'hA000_0000, 2'b00, 0);
            drive(1, 4, 32'hB000_0000, 2'b00, 0);
            drive(2, 4, 32'hC000_0000, 2'b00, 0);
        join
        drain();
        chk("a_count", 32'(q.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            logic [31:0] e;
            e = (i < 4) ? 32'hA000_0000 : (i < 8) ? 32'hB000_0000
                                                  : 32'hC000_0000;
            chk($sformatf("a_data%0d", i), q[i].d, e + 32'(i % 4));
            chk($sformatf("a_last%0d", i), 32'(q[i].l), 32'(i % 4 == 3));
        end
        chk("a_rid_s2", 32'(q[8].id), 32'd3);
        chk("a_b2b", 32'(q[11].c - q[0].c), 32'd11);
        chk("a_ptr", 32'(dut.ptr_q), 32'd0);

        // s0 arrives mid s1 burst and must wait for rlast
        q.delete();
        fork
            drive(1, 4, 32'hB100_0000, 2'b00, 0);
            drive(0, 2, 32'hA100_0000, 2'b00, 2);
        join
        drain();
        chk("b_count", 32'(q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] e;
            e = (i < 4) ? 32'hB100_0000 + 32'(i)
                        : 32'hA100_0000 + 32'(i - 4);
            chk($sformatf("b_data%0d", i), q[i].d, e);
        end
        chk("b_next", 32'(q[4].c - q[3].c), 32'd1);

        // s2 8-beat burst with toggling master ready
        q.delete();
        sn = stall_n;
        se = stall_err;
        fork
            drive(2, 8, 32'h0000_0100, 2'b00, 0);
            begin
                for (int i = 0; i < 20; i++) begin
                    m_ready = ~m_ready;
                    @(posedge clk);
                    #1;
                end
                m_ready = 1'b1;
            end
        join
        drain();
        chk("c_count", 32'(q.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("c_data%0d", i), q[i].d, 32'h100 + 32'(i));
        chk("c_last", 32'(q[7].l), 32'd1);
        chk("c_stalled", 32'(stall_n - sn > 0), 32'd1);
        chk("c_stable", 32'(stall_err - se), 32'd0);

        // Single-beat bursts, s1 with SLVERR
        q.delete();
        ln = lock_n;
        fork
            drive(0, 1, 32'hD000_0000, RRESP_OKAY, 0);
            drive(1, 1, 32'hD100_0000, RRESP_SLVERR, 0);
            drive(2, 1, 32'hD200_0000, RRESP_OKAY, 0);
        join
        drain();
        chk("d_count", 32'(q.size()), 32'd3);
        chk("d_data0", q[0].d, 32'hD000_0000);
        chk("d_data1", q[1].d, 32'hD100_0000);
        chk("d_data2", q[2].d, 32'hD200_0000);
        chk("d_resp0", 32'(q[0].r), 32'(RRESP_OKAY));
        chk("d_resp1", 32'(q[1].r), 32'(RRESP_SLVERR));
        chk("d_nolock", 32'(lock_n - ln), 32'd0);

        // Reset asserted at beat 2 of an s0 burst
        s_rid[0]   = 4'd1;
        s_resp[0]  = 2'b00;
        s_last[0]  = 1'b0;
        s_data[0]  = 32'hE000_0000;
        s_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        s_data[0] = 32'hE000_0001;
        @(posedge clk);
        #1;
        s_data[0] = 32'hE000_0002;
        chk("e_locked", 32'(dut.state_q), 32'(ST_LOCK));
        chk("e_pre_valid", 32'(m_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("e_mvalid", 32'(m_valid), 32'd0);
        chk("e_ready", 32'(s_ready), 32'd0);
        chk("e_mdata", m_data, 32'd0);
        chk("e_mlast", 32'(m_last), 32'd0);
        chk("e_state", 32'(dut.state_q), 32'(ST_IDLE));
        s_valid[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        fork
            drive(2, 2, 32'hF200_0000, 2'b00, 0);
            drive(1, 2, 32'hF100_0000, 2'b00, 0);
        join
        drain();
        chk("e_count", 32'(q.size()), 32'd4);
        chk("e_data0", q[0].d, 32'hF100_0000);
        chk("e_data1", q[1].d, 32'hF100_0001);
        chk("e_data2", q[2].d, 32'hF200_0000);
        chk("e_data3", q[3].d, 32'hF200_0001);

        // Output latency
        q.delete();
        s_data[0]  = 32'h0000_0055;
        s_last[0]  = 1'b1;
        s_rid[0]   = 4'd1;
        s_valid[0] = 1'b1;
        #1;
        chk("f_lat_now", 32'(m_valid), 32'(LAT == 0));
        @(posedge clk);
        #1;
        s_valid[0] = 1'b0;
        s_last[0]  = 1'b0;
        #1;
        chk("f_lat_next", 32'(m_valid), 32'(LAT == 1));
        drain();
        chk("f_count", 32'(q.size()), 32'd1);
        chk("f_data", q[0].d, 32'h0000_0055);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
